// File: rtl/dcache_pkg.sv
// Shared state encodings and byte-lane helpers for the write-through data cache.
package dcache_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_RFILL = 2'd1;
  localparam state_t S_WTHRU = 2'd2;

  function automatic logic [3:0] size_to_strb(input logic [1:0] offset, input logic sw,
                                              input logic sh, input logic sb);
    logic [3:0] strb;
    strb = 4'b0000;
    if (sw)      strb = 4'b1111;
    else if (sh) strb = offset[1] ? 4'b1100 : 4'b0011;
    else if (sb) strb = 4'b0001 << offset;
    return strb;
  endfunction

  // Store data replicated into every lane it could land in; the strobe picks the live ones.
  function automatic logic [31:0] store_lanes(input logic [31:0] wdata, input logic sw,
                                              input logic sh, input logic sb);
    logic [31:0] lanes;
    lanes = wdata;
    if (sb)      lanes = {4{wdata[7:0]}};
    else if (sh) lanes = {2{wdata[15:0]}};
    else if (sw) lanes = wdata;
    return lanes;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] offset,
                                               input logic lw, input logic lh, input logic lb);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b   = word[{offset, 3'b000} +: 8];
    h   = offset[1] ? word[31:16] : word[15:0];
    res = '0;
    if (lw)      res = word;
    else if (lh) res = {{16{h[15]}}, h};
    else if (lb) res = {{24{b[7]}}, b};
    return res;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage for the direct-mapped cache: async read, strobed sync write.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int SETS    = 64,
  parameter int INDEX_W = $clog2(SETS),
  parameter int TAG_W   = 24,
  parameter int WIDTH   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] rd_index,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [WIDTH-1:0]   rd_data,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic [3:0]         wr_strb
);

  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [WIDTH-1:0] data_q [SETS];

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= '0;
    else if (wr_en) valid_q[wr_index] <= 1'b1;
  end

  // Tag and data need no reset: nothing reads them while the valid bit is clear.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_index] <= wr_tag;
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b]) data_q[wr_index][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/dcache_wt.sv
// Direct-mapped write-through, no-write-allocate data cache in front of a slow data memory.
// state   | meaning
// IDLE    | accepting requests; load hits return combinationally
// RFILL   | load miss outstanding, waiting for mem_ready to fill the line
// WTHRU   | store outstanding, waiting for mem_ready; merge into line on hit
module dcache_wt
  import dcache_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SETS    = 64,
  parameter int INDEX_W = $clog2(SETS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lw_M,
  input  logic             lh_M,
  input  logic             lb_M,
  input  logic             sw_M,
  input  logic             sh_M,
  input  logic             sb_M,
  input  logic [WIDTH-1:0] addr_M,
  input  logic [WIDTH-1:0] wdata_M,
  output logic [WIDTH-1:0] rdata_M,
  output logic             stall_M,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [3:0]       mem_wstrb,
  input  logic             mem_ready,
  input  logic [WIDTH-1:0] mem_rdata
);

  localparam int TAG_W = WIDTH - INDEX_W - 2;

  state_t             state_q;
  logic [INDEX_W-1:0] index;
  logic [TAG_W-1:0]   tag;
  logic               rd_valid;
  logic [TAG_W-1:0]   rd_tag;
  logic [WIDTH-1:0]   rd_data;
  logic               hit;
  logic               load_req;
  logic               store_req;
  logic               fill;
  logic               merge;
  logic               wr_en;
  logic [WIDTH-1:0]   wr_data;
  logic [3:0]         wr_strb;

  assign index     = addr_M[INDEX_W+1:2];
  assign tag       = addr_M[WIDTH-1:INDEX_W+2];
  assign hit       = rd_valid && (rd_tag == tag);
  assign load_req  = lw_M | lh_M | lb_M;
  assign store_req = sw_M | sh_M | sb_M;

  // addr_M is held while stalled, so the array read still reflects the outstanding line.
  assign fill    = (state_q == S_RFILL) && mem_ready;
  assign merge   = (state_q == S_WTHRU) && mem_ready && hit;
  assign wr_en   = fill | merge;
  assign wr_data = fill ? mem_rdata : mem_wdata;
  assign wr_strb = fill ? 4'b1111 : mem_wstrb;

  dcache_array #(
    .SETS    (SETS),
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W),
    .WIDTH   (WIDTH)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_index (index),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_index (mem_addr[INDEX_W+1:2]),
    .wr_tag   (mem_addr[WIDTH-1:INDEX_W+2]),
    .wr_data  (wr_data),
    .wr_strb  (wr_strb)
  );

  always_comb begin
    stall_M = 1'b0;
    rdata_M = '0;
    if (!rst) begin
      case (state_q)
        S_IDLE: begin
          if (store_req) begin
            stall_M = 1'b1;
          end else if (load_req) begin
            stall_M = !hit;
            if (hit) rdata_M = load_extract(rd_data, addr_M[1:0], lw_M, lh_M, lb_M);
          end
        end
        default: stall_M = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (store_req) begin
            state_q   <= S_WTHRU;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {addr_M[WIDTH-1:2], 2'b00};
            mem_wdata <= store_lanes(wdata_M, sw_M, sh_M, sb_M);
            mem_wstrb <= size_to_strb(addr_M[1:0], sw_M, sh_M, sb_M);
          end else if (load_req && !hit) begin
            state_q   <= S_RFILL;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= {addr_M[WIDTH-1:2], 2'b00};
            mem_wstrb <= 4'b0000;
          end
        end
        S_RFILL, S_WTHRU: begin
          if (mem_ready) begin
            state_q <= S_IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_wt.sv
// Randomized bench for dcache_wt against a line-map cache model and a backing-memory model.
module tb_dcache_wt;
  localparam int WIDTH = 32;
  localparam int SETS  = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        lw_M, lh_M, lb_M, sw_M, sh_M, sb_M;
  logic [31:0] addr_M, wdata_M;
  logic [31:0] rdata_M;
  logic        stall_M;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  logic [31:0] bmem [logic [31:0]];
  logic [31:0] line_addr [int];
  logic [31:0] line_val  [int];

  dcache_wt #(.WIDTH(WIDTH), .SETS(SETS)) dut (
    .clk(clk), .rst(rst),
    .lw_M(lw_M), .lh_M(lh_M), .lb_M(lb_M), .sw_M(sw_M), .sh_M(sh_M), .sb_M(sb_M),
    .addr_M(addr_M), .wdata_M(wdata_M), .rdata_M(rdata_M), .stall_M(stall_M),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] wa);
    if (!bmem.exists(wa)) bmem[wa] = $urandom;
    return bmem[wa];
  endfunction

  // size: 0 byte, 1 half, 2 word
  function automatic logic [31:0] pick(input logic [31:0] word, input int size, input int off);
    logic [31:0] sh;
    if (size == 2) return word;
    if (size == 1) begin
      sh = word >> ((off / 2) * 16);
      return sh[15] ? (sh | 32'hFFFF0000) : (sh & 32'h0000FFFF);
    end
    sh = word >> (off * 8);
    return sh[7] ? (sh | 32'hFFFFFF00) : (sh & 32'h000000FF);
  endfunction

  function automatic logic [31:0] apply_store(input logic [31:0] word, input logic [31:0] d,
                                              input int size, input int off);
    logic [31:0] r;
    r = word;
    if (size == 2) r = d;
    else if (size == 1) begin
      if (off >= 2) r = {d[15:0], word[15:0]};
      else          r = {word[31:16], d[15:0]};
    end else begin
      for (int k = 0; k < 4; k++)
        if (k == off) r = (word & ~(32'hFF << (8 * k))) | ({24'h0, d[7:0]} << (8 * k));
    end
    return r;
  endfunction

  task automatic set_req(input bit is_st, input int size, input bit on);
    lw_M = on && !is_st && size == 2;
    lh_M = on && !is_st && size == 1;
    lb_M = on && !is_st && size == 0;
    sw_M = on && is_st && size == 2;
    sh_M = on && is_st && size == 1;
    sb_M = on && is_st && size == 0;
  endtask

  task automatic do_op(input bit is_st, input int size, input logic [31:0] a,
                       input logic [31:0] d, input int lat_in);
    logic [31:0] wa;
    logic [31:0] exp_lanes;
    logic [3:0]  exp_strb;
    int          idx, off, lat, stalls;
    bit          hit;
    wa  = {a[31:2], 2'b00};
    idx = int'(a[7:2]);
    off = int'(a[1:0]);
    hit = line_addr.exists(idx) && line_addr[idx] == wa;
    @(negedge clk);
    addr_M = a; wdata_M = d; set_req(is_st, size, 1'b1);
    #1;
    if (!is_st && hit) begin
      chk_eq("hit_stall", {31'b0, stall_M}, 0);
      chk_eq("hit_rdata", rdata_M, pick(line_val[idx], size, off));
      chk_eq("hit_no_req", {31'b0, mem_req}, 0);
      @(negedge clk);
      set_req(0, 0, 1'b0);
      return;
    end
    chk_eq("req_stall", {31'b0, stall_M}, 1);
    lat = (lat_in == 0) ? int'($urandom_range(1, 4)) : lat_in;
    stalls = 1;
    if (size == 2)      begin exp_strb = 4'hF; exp_lanes = d; end
    else if (size == 1) begin exp_strb = (off >= 2) ? 4'hC : 4'h3; exp_lanes = {d[15:0], d[15:0]}; end
    else                begin exp_strb = 4'h1 << off; exp_lanes = {4{d[7:0]}}; end
    @(negedge clk);
    chk_eq("mem_req", {31'b0, mem_req}, 1);
    chk_eq("mem_we", {31'b0, mem_we}, {31'b0, is_st});
    chk_eq("mem_addr", mem_addr, wa);
    if (is_st) begin
      chk_eq("mem_wstrb", {28'b0, mem_wstrb}, {28'b0, exp_strb});
      chk_eq("mem_wdata", mem_wdata, exp_lanes);
    end
    repeat (lat - 1) begin
      if (stall_M && mem_req) stalls++;
      @(negedge clk);
    end
    if (stall_M && mem_req) stalls++;
    mem_ready = 1'b1;
    mem_rdata = is_st ? $urandom : mem_rd(wa);
    @(negedge clk);
    mem_ready = 1'b0;
    mem_rdata = $urandom;
    chk_eq("mem_req_drop", {31'b0, mem_req}, 0);
    chk_eq("stall_cycles", stalls, lat + 1);
    if (is_st) begin
      bmem[wa] = apply_store(mem_rd(wa), d, size, off);
      if (hit) line_val[idx] = apply_store(line_val[idx], d, size, off);
      set_req(0, 0, 1'b0);
      #1;
      chk_eq("store_done_stall", {31'b0, stall_M}, 0);
    end else begin
      line_addr[idx] = wa;
      line_val[idx]  = mem_rd(wa);
      #1;
      chk_eq("fill_stall", {31'b0, stall_M}, 0);
      chk_eq("fill_rdata", rdata_M, pick(line_val[idx], size, off));
      @(negedge clk);
      set_req(0, 0, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; mem_ready = 1'b0; mem_rdata = '0;
    addr_M = '0; wdata_M = '0; set_req(0, 0, 1'b0);
    repeat (3) @(negedge clk);
    chk_eq("rst_mem_req", {31'b0, mem_req}, 0);
    chk_eq("rst_mem_we", {31'b0, mem_we}, 0);
    chk_eq("rst_mem_addr", mem_addr, 0);
    chk_eq("rst_mem_wdata", mem_wdata, 0);
    chk_eq("rst_mem_wstrb", {28'b0, mem_wstrb}, 0);
    chk_eq("rst_stall", {31'b0, stall_M}, 0);
    chk_eq("rst_rdata", rdata_M, 0);
    rst = 1'b0;

    bmem[32'h100] = 32'hDEADBEEF;
    do_op(0, 2, 32'h100, 0, 3);
    do_op(0, 2, 32'h100, 0, 0);
    do_op(0, 0, 32'h103, 0, 0);
    do_op(0, 1, 32'h100, 0, 0);
    do_op(1, 0, 32'h101, 32'h12, 2);
    do_op(0, 2, 32'h100, 0, 0);
    do_op(1, 2, 32'h200, 32'h5, 0);
    do_op(0, 2, 32'h200, 0, 0);
    do_op(0, 2, 32'h100, 0, 0);
    do_op(0, 2, 32'h100 + 4 * SETS, 0, 0);
    do_op(0, 2, 32'h100, 0, 0);

    @(negedge clk);
    #1;
    chk_eq("idle_stall", {31'b0, stall_M}, 0);
    chk_eq("idle_rdata", rdata_M, 0);
    chk_eq("idle_mem_req", {31'b0, mem_req}, 0);

    // Reset in the middle of a line fill
    @(negedge clk);
    addr_M = 32'h300; set_req(0, 2, 1'b1);
    @(negedge clk);
    chk_eq("mid_fill_req", {31'b0, mem_req}, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_eq("mid_rst_req", {31'b0, mem_req}, 0);
    chk_eq("mid_rst_stall", {31'b0, stall_M}, 0);
    @(negedge clk);
    rst = 1'b0;
    set_req(0, 0, 1'b0);
    mem_ready = 1'b1; mem_rdata = 32'h0BADF00D;
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chk_eq("late_ready_req", {31'b0, mem_req}, 0);
    chk_eq("late_ready_stall", {31'b0, stall_M}, 0);
    line_addr.delete();
    line_val.delete();
    do_op(0, 2, 32'h100, 0, 0);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) * 4 * SETS) + ($urandom_range(0, 7) * 4) + $urandom_range(0, 3);
      do_op($urandom_range(0, 2) == 0, int'($urandom_range(0, 2)), a, $urandom, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dcache_wt.md
Name: dcache_wt

Overview:
- Direct-mapped, write-through, no-write-allocate data cache.
- Sits directly downstream of the memory-stage request signals (ALU result address, store data, one-hot store/load size) and in front of a slower backing data memory.
- On a load hit it returns data combinationally in the same cycle; on a load miss or any store it raises a stall until the backing memory completes.
- The pipeline holds all stages while stall_M is high.

Parameters:
- WIDTH, 32, data/address width in bits.
- SETS, 64, number of one-word lines (power of 2, ≥2).
- INDEX_W, $clog2(SETS), index bits taken from addr[INDEX_W+1:2].

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous reset, active-high
- lw_M, lh_M, lb_M  input  1 each  one-hot load request (word/half/byte)
- sw_M, sh_M, sb_M  input  1 each  one-hot store request
- addr_M  input  WIDTH  byte address (ALUResult_M)
- wdata_M  input  WIDTH  store data, value in low bits
- rdata_M  output  WIDTH  load result, sign-extended
- stall_M  output  1  high = hold pipeline, request not complete
- mem_req  output  1  backing-memory request valid
- mem_we  output  1  1 = write, 0 = read
- mem_addr  output  WIDTH  word-aligned address (low 2 bits zero)
- mem_wdata  output  WIDTH  byte-lane-positioned store data
- mem_wstrb  output  4  byte enables for the write
- mem_ready  input  1  one-cycle pulse: request done (read data valid)
- mem_rdata  input  WIDTH  read word

Behaviour:
- Reset is asynchronous and active-high.
  - All valid bits = 0; state = IDLE.
  - mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, mem_wstrb = 0.
  - stall_M = 0 (no request asserted), rdata_M = 0.
- Address split:
  - offset = addr[1:0].
  - index = addr[INDEX_W+1:2].
  - tag = addr[WIDTH-1:INDEX_W+2].
  - Half accesses ignore addr[0].
  - Misalignment is not trapped.
- Storage: per line, a valid bit, a tag and a WIDTH data word. Arrays are read asynchronously and written on the clk rising edge.
- hit = valid[index] & (tag_arr[index] == tag).
- States:
  - IDLE
  - RFILL (read miss outstanding)
  - WTHRU (store outstanding)
- IDLE:
  - Load & hit:
    - stall_M = 0.
    - rdata_M = selected byte/half/word from the line, sign-extended. Zero cycles of added latency.
  - Load & miss:
    - stall_M = 1 combinationally.
    - Next state RFILL; registered mem_req = 1, mem_we = 0, mem_addr = {addr[WIDTH-1:2], 2'b00}.
  - Store (any size):
    - stall_M = 1.
    - Next state WTHRU; mem_req = 1, mem_we = 1.
    - mem_wdata = wdata replicated into lanes: sb → byte in all 4 lanes, sh → half in both halves.
    - mem_wstrb: sb = 0001 << offset; sh = 0011 << (offset[1]*2); sw = 1111.
  - No request: stall_M = 0, rdata_M = 0.
- RFILL:
  - stall_M = 1; mem_req is held stable until mem_ready.
  - On mem_ready: write data/tag into line index, set valid, drop mem_req, return to IDLE.
  - The next cycle is a hit, so stall_M falls and rdata_M is valid. Load-miss penalty = memory latency + 1 cycle.
- WTHRU:
  - stall_M = 1; mem_req is held until mem_ready.
  - On mem_ready:
    - If the line hits, merge the strobed bytes into the cached word. No-write-allocate: a miss does not change cache state.
    - Return to IDLE.
  - stall_M is 0 in the cycle after mem_ready. The pipeline has advanced by then, so the same store is not reissued.
- Invariants:
  - The request inputs and addr_M are stable while stall_M = 1; the pipeline guarantees this.
  - mem_ready outside RFILL/WTHRU is ignored.
  - A load and a store asserted together is illegal; a store takes priority.
- Reset mid-RFILL/WTHRU:
  - mem_req drops immediately and all lines are invalidated.
  - A late mem_ready after reset is ignored.
- mem_ready arriving in the same cycle as mem_req first rises is impossible: mem_req is registered and the memory samples it on the next edge.

Decomposition:
- Shared package dcache_pkg:
  - state enum {IDLE, RFILL, WTHRU}.
  - Function size_to_strb(offset, sw, sh, sb) → 4-bit strobe.
  - Function load_extract(word, offset, lw, lh, lb) → sign-extended WIDTH result.
- One natural sub-module, dcache_array:
  - valid/tag/data storage.
  - Async read; sync write with byte strobes.
  - Async clear on rst.
- The FSM and memory interface stay in dcache_wt.

Test Plan:
- Cold load: reset, lw addr 0x100 with memory returning 0xDEADBEEF after 3 cycles → stall_M high 4 cycles, mem_req/mem_we=0/mem_addr=0x100, then rdata_M=0xDEADBEEF with stall_M=0.
- Hit: repeat lw 0x100 → stall_M=0 same cycle, no mem_req; then lb 0x103 → rdata_M=0xFFFFFFDE; lh 0x100 → 0xFFFFBEEF.
- Store hit merge: sb 0x101 wdata 0x12 → mem_wstrb=0010, mem_wdata=0x12121212; after mem_ready, lw 0x100 hits → 0xDEAD12EF.
- Store miss no-allocate: sw 0x200 data 0x5 → write issued with mem_wstrb=1111; lw 0x200 next → miss, mem read issued.
- Conflict: lw 0x100 then lw 0x100+4*SETS (same index, different tag) → second misses and evicts; lw 0x100 misses again.
- Reset mid-fill: rst asserted during RFILL → mem_req=0 immediately, stall_M=0; mem_ready pulse after release ignored; lw 0x100 misses.
